// File: rtl/udp_rx_packet_buffer_if.sv
// Receive word stream from the UDP serial port FIFO: valid/ready/last,
// the final-byte index and one 32-bit data word per beat.
interface udp_rx_packet_buffer_if;
    logic        sysRxValid;
    logic        sysRxReady;
    logic        sysRxLast;
    logic [1:0]  sysByteIndex;
    logic [31:0] sysRxData;

    modport master (
        output sysRxValid,
        output sysRxLast,
        output sysByteIndex,
        output sysRxData,
        input  sysRxReady
    );

    modport slave (
        input  sysRxValid,
        input  sysRxLast,
        input  sysByteIndex,
        input  sysRxData,
        output sysRxReady
    );
endinterface

// File: rtl/udp_rx_packet_buffer.sv
// Assembles received UDP packets into a two-slot ping-pong RAM and presents
// one complete packet at a time to the CPU; oversize/overflow packets are dropped.
module udp_rx_packet_buffer #(
    parameter int ADDR_WIDTH = 11,
    parameter int DROP_WIDTH = 16
) (
    input  logic                    sysClk,
    input  logic                    sysReset,
    udp_rx_packet_buffer_if.slave   rxStream,
    input  logic [ADDR_WIDTH-3:0]   cpuReadAddr,
    output logic [31:0]             cpuReadData,
    output logic                    pktAvail,
    output logic [ADDR_WIDTH:0]     pktLength,
    input  logic                    pktRelease,
    output logic [DROP_WIDTH-1:0]   dropCount
);
    localparam int WA_W       = ADDR_WIDTH - 2;
    localparam int WC_W       = ADDR_WIDTH - 1;
    localparam int LEN_W      = ADDR_WIDTH + 1;
    localparam int SLOT_WORDS = 1 << WA_W;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DISCARD
    } wrState_t;

    function automatic logic [DROP_WIDTH-1:0] satInc(input logic [DROP_WIDTH-1:0] v);
        return (&v) ? v : v + DROP_WIDTH'(1);
    endfunction

    wrState_t          wrState, wrStateNext;
    logic [WC_W-1:0]   wordCount, wordCountNext;
    logic              wrSlot, rdSlot, rdSlotNext;
    logic [1:0]        full, fullNext;
    logic [LEN_W-1:0]  lenReg [2];
    logic [LEN_W-1:0]  cmpLen, lenBase, pktLengthNext;
    logic              rxReady;
    logic              beat, ramWe, dropEvt, completeEvt, relEvt;
    logic [WA_W-1:0]   wrWordAddr;
    logic [31:0]       mem [2*SLOT_WORDS];

    assign rxStream.sysRxReady = rxReady;
    assign beat   = rxStream.sysRxValid && rxReady;
    assign relEvt = pktRelease && pktAvail;

    // Word count before this beat determines the completed length.
    assign lenBase = (wrState == IDLE) ? '0 : {wordCount, 2'b00};
    assign cmpLen  = lenBase + LEN_W'(rxStream.sysByteIndex) + LEN_W'(1);

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            wrState <= IDLE;
        end else begin
            wrState <= wrStateNext;
        end
    end

    always_comb begin
        wrStateNext   = wrState;
        wordCountNext = wordCount;
        ramWe         = 1'b0;
        dropEvt       = 1'b0;
        completeEvt   = 1'b0;
        wrWordAddr    = '0;
        if (beat) begin
            case (wrState)
                IDLE: begin
                    if (full[wrSlot]) begin
                        dropEvt = 1'b1;
                        if (!rxStream.sysRxLast) wrStateNext = DISCARD;
                    end else begin
                        ramWe         = 1'b1;
                        wordCountNext = WC_W'(1);
                        if (rxStream.sysRxLast) completeEvt = 1'b1;
                        else                    wrStateNext = FILL;
                    end
                end
                FILL: begin
                    if (wordCount == WC_W'(SLOT_WORDS)) begin
                        dropEvt     = 1'b1;
                        wrStateNext = rxStream.sysRxLast ? IDLE : DISCARD;
                    end else begin
                        ramWe         = 1'b1;
                        wrWordAddr    = wordCount[WA_W-1:0];
                        wordCountNext = wordCount + WC_W'(1);
                        if (rxStream.sysRxLast) begin
                            completeEvt = 1'b1;
                            wrStateNext = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (rxStream.sysRxLast) wrStateNext = IDLE;
                end
                default: wrStateNext = IDLE;
            endcase
        end
    end

    // Presentation registers follow next-state slot flags so a release or
    // completion is visible on the very next cycle.
    always_comb begin
        fullNext = full;
        if (completeEvt) fullNext[wrSlot] = 1'b1;
        if (relEvt)      fullNext[rdSlot] = 1'b0;
        rdSlotNext = rdSlot ^ relEvt;
        if (completeEvt && (wrSlot == rdSlotNext)) pktLengthNext = cmpLen;
        else                                       pktLengthNext = lenReg[rdSlotNext];
    end

    always_ff @(posedge sysClk) begin
        if (ramWe) mem[{wrSlot, wrWordAddr}] <= rxStream.sysRxData;
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            rxReady     <= 1'b0;
            wordCount   <= '0;
            wrSlot      <= 1'b0;
            rdSlot      <= 1'b0;
            full        <= '0;
            lenReg[0]   <= '0;
            lenReg[1]   <= '0;
            pktAvail    <= 1'b0;
            pktLength   <= '0;
            dropCount   <= '0;
            cpuReadData <= '0;
        end else begin
            rxReady   <= 1'b1;
            wordCount <= wordCountNext;
            if (completeEvt) begin
                lenReg[wrSlot] <= cmpLen;
                wrSlot         <= ~wrSlot;
            end
            full        <= fullNext;
            rdSlot      <= rdSlotNext;
            pktAvail    <= fullNext[rdSlotNext];
            pktLength   <= pktLengthNext;
            if (dropEvt) dropCount <= satInc(dropCount);
            cpuReadData <= mem[{rdSlot, cpuReadAddr}];
        end
    end
endmodule

// File: tb/tb_udp_rx_packet_buffer.sv
// Directed bench for udp_rx_packet_buffer: table of single-packet cases plus
// hand sequences for drops, release timing, reset and counter saturation.
module tb_udp_rx_packet_buffer;
    localparam int AW = 11;
    localparam int DW = 3;

    logic          sysClk = 1'b0;
    logic          sysReset;
    logic [AW-3:0] cpuReadAddr;
    logic [31:0]   cpuReadData;
    logic          pktAvail;
    logic [AW:0]   pktLength;
    logic          pktRelease;
    logic [DW-1:0] dropCount;

    int errors = 0;
    int checks = 0;

    always #5 sysClk = ~sysClk;

    udp_rx_packet_buffer_if rxStream();

    udp_rx_packet_buffer #(.ADDR_WIDTH(AW), .DROP_WIDTH(DW)) dut (
        .sysClk      (sysClk),
        .sysReset    (sysReset),
        .rxStream    (rxStream),
        .cpuReadAddr (cpuReadAddr),
        .cpuReadData (cpuReadData),
        .pktAvail    (pktAvail),
        .pktLength   (pktLength),
        .pktRelease  (pktRelease),
        .dropCount   (dropCount)
    );

    typedef struct {
        string      name;
        int         nWords;
        logic [1:0] idx;
        logic       expAvail;
        int         expLen;
        int         expDrop;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic applyReset();
        sysReset = 1'b1;
        rxStream.sysRxValid = 1'b0;
        rxStream.sysRxLast  = 1'b0;
        pktRelease = 1'b0;
        tick();
        tick();
        sysReset = 1'b0;
        tick();
    endtask

    task automatic sendBeat(input logic [31:0] d, input logic lst, input logic [1:0] idx, input logic rel);
        rxStream.sysRxValid   = 1'b1;
        rxStream.sysRxData    = d;
        rxStream.sysRxLast    = lst;
        rxStream.sysByteIndex = idx;
        pktRelease            = rel;
        tick();
        rxStream.sysRxValid = 1'b0;
        rxStream.sysRxLast  = 1'b0;
        pktRelease          = 1'b0;
    endtask

    task automatic sendPkt(input int n, input logic [1:0] idx, input logic [31:0] base);
        for (int i = 0; i < n; i++) sendBeat(base + 32'(i), (i == n - 1), idx, 1'b0);
    endtask

    task automatic releasePkt();
        pktRelease = 1'b1;
        tick();
        pktRelease = 1'b0;
    endtask

    task automatic readWord(input string name, input int addr, input logic [31:0] exp);
        cpuReadAddr = (AW-2)'(addr);
        tick();
        check(name, cpuReadData, exp);
    endtask

    initial begin
        vecs[0] = '{"len9",     3,   2'd0, 1'b1, 9,    0};
        vecs[1] = '{"len4",     1,   2'd3, 1'b1, 4,    0};
        vecs[2] = '{"len1",     1,   2'd0, 1'b1, 1,    0};
        vecs[3] = '{"len8",     2,   2'd3, 1'b1, 8,    0};
        vecs[4] = '{"len14",    4,   2'd1, 1'b1, 14,   0};
        vecs[5] = '{"len2048",  512, 2'd3, 1'b1, 2048, 0};
        vecs[6] = '{"oversize", 513, 2'd0, 1'b0, 0,    1};

        sysReset = 1'b1;
        rxStream.sysRxValid   = 1'b0;
        rxStream.sysRxLast    = 1'b0;
        rxStream.sysByteIndex = 2'd0;
        rxStream.sysRxData    = '0;
        cpuReadAddr = '0;
        pktRelease  = 1'b0;
        #1;
        check("rst_ready", 32'(rxStream.sysRxReady), 32'd0);
        check("rst_avail", 32'(pktAvail), 32'd0);
        check("rst_len",   32'(pktLength), 32'd0);
        check("rst_drop",  32'(dropCount), 32'd0);
        check("rst_data",  cpuReadData, 32'd0);
        applyReset();
        check("ready_after_rst", 32'(rxStream.sysRxReady), 32'd1);

        for (int k = 0; k < 7; k++) begin
            logic [31:0] base;
            base = {8'(k + 1), 24'h0};
            applyReset();
            sendPkt(vecs[k].nWords, vecs[k].idx, base);
            check({vecs[k].name, "_avail"}, 32'(pktAvail), 32'(vecs[k].expAvail));
            check({vecs[k].name, "_drop"}, 32'(dropCount), 32'(vecs[k].expDrop));
            if (vecs[k].expAvail) begin
                check({vecs[k].name, "_len"}, 32'(pktLength), 32'(vecs[k].expLen));
                readWord({vecs[k].name, "_lastword"}, vecs[k].nWords - 1,
                         base + 32'(vecs[k].nWords - 1));
            end
        end

        // 9-byte packet readback
        applyReset();
        sendBeat(32'h11111111, 1'b0, 2'd0, 1'b0);
        sendBeat(32'h22222222, 1'b0, 2'd0, 1'b0);
        check("t1_not_yet", 32'(pktAvail), 32'd0);
        sendBeat(32'h33333333, 1'b1, 2'd0, 1'b0);
        check("t1_avail", 32'(pktAvail), 32'd1);
        check("t1_len", 32'(pktLength), 32'd9);
        readWord("t1_w0", 0, 32'h11111111);
        readWord("t1_w1", 1, 32'h22222222);
        readWord("t1_w2", 2, 32'h33333333);

        // Two single-word packets, then release
        applyReset();
        sendBeat(32'hAAAA0001, 1'b1, 2'd3, 1'b0);
        sendBeat(32'hAAAA0002, 1'b1, 2'd0, 1'b0);
        check("t2_len4", 32'(pktLength), 32'd4);
        releasePkt();
        check("t2_avail2", 32'(pktAvail), 32'd1);
        check("t2_len1", 32'(pktLength), 32'd1);
        readWord("t2_data2", 0, 32'hAAAA0002);
        releasePkt();
        check("t2_empty", 32'(pktAvail), 32'd0);

        // Overflow drop and slot reuse
        applyReset();
        sendPkt(2, 2'd3, 32'hA0);
        sendPkt(2, 2'd3, 32'hB0);
        sendPkt(2, 2'd3, 32'hC0);
        check("t3_drop", 32'(dropCount), 32'd1);
        check("t3_len", 32'(pktLength), 32'd8);
        readWord("t3_dataA", 0, 32'hA0);
        releasePkt();
        check("t3_availB", 32'(pktAvail), 32'd1);
        readWord("t3_dataB", 1, 32'hB1);
        sendPkt(3, 2'd3, 32'hD0);
        check("t3_stillB", 32'(pktLength), 32'd8);
        check("t3_drop_same", 32'(dropCount), 32'd1);
        releasePkt();
        check("t3_lenD", 32'(pktLength), 32'd12);
        readWord("t3_dataD", 2, 32'hD2);

        // Oversize followed by a normal packet
        applyReset();
        sendPkt(513, 2'd0, 32'h7000);
        check("t4_noavail", 32'(pktAvail), 32'd0);
        sendPkt(1, 2'd3, 32'h7777);
        check("t4_avail", 32'(pktAvail), 32'd1);
        check("t4_len", 32'(pktLength), 32'd4);
        check("t4_drop", 32'(dropCount), 32'd1);
        readWord("t4_data", 0, 32'h7777);

        // Release while empty; release coincident with completion
        applyReset();
        releasePkt();
        check("t5_idle_avail", 32'(pktAvail), 32'd0);
        check("t5_idle_drop", 32'(dropCount), 32'd0);
        sendPkt(1, 2'd3, 32'h50);
        check("t5_avail0", 32'(pktAvail), 32'd1);
        check("t5_len0", 32'(pktLength), 32'd4);
        sendBeat(32'h60, 1'b0, 2'd1, 1'b0);
        sendBeat(32'h61, 1'b1, 2'd1, 1'b1);
        check("t5_coinc_avail", 32'(pktAvail), 32'd1);
        check("t5_coinc_len", 32'(pktLength), 32'd6);
        readWord("t5_coinc_data", 1, 32'h61);
        sendPkt(1, 2'd0, 32'h70);
        sendBeat(32'h80, 1'b1, 2'd2, 1'b1);
        check("t5_rel_first_drop", 32'(dropCount), 32'd1);
        check("t5_rel_first_len", 32'(pktLength), 32'd1);
        readWord("t5_rel_first_data", 0, 32'h70);

        // Asynchronous reset mid-packet
        applyReset();
        sendPkt(1, 2'd3, 32'hC0);
        readWord("t6_pre_data", 0, 32'hC0);
        for (int i = 0; i < 5; i++) sendBeat(32'hE0 + 32'(i), 1'b0, 2'd0, 1'b0);
        rxStream.sysRxValid = 1'b1;
        #2;
        sysReset = 1'b1;
        #1;
        check("t6_rst_ready", 32'(rxStream.sysRxReady), 32'd0);
        check("t6_rst_avail", 32'(pktAvail), 32'd0);
        check("t6_rst_len", 32'(pktLength), 32'd0);
        check("t6_rst_data", cpuReadData, 32'd0);
        rxStream.sysRxValid = 1'b0;
        tick();
        sysReset = 1'b0;
        tick();
        check("t6_ready", 32'(rxStream.sysRxReady), 32'd1);
        sendPkt(3, 2'd3, 32'hD0);
        check("t6_avail", 32'(pktAvail), 32'd1);
        check("t6_len", 32'(pktLength), 32'd12);
        check("t6_drop", 32'(dropCount), 32'd0);
        readWord("t6_data", 0, 32'hD0);

        // Drop counter saturation (DROP_WIDTH=3)
        applyReset();
        sendPkt(1, 2'd0, 32'h1);
        sendPkt(1, 2'd1, 32'h2);
        sendPkt(3, 2'd0, 32'h3);
        check("sat_multiword_once", 32'(dropCount), 32'd1);
        check("sat_len_kept", 32'(pktLength), 32'd1);
        for (int i = 0; i < 6; i++) sendPkt(1, 2'd0, 32'h4);
        check("sat_at_max", 32'(dropCount), 32'd7);
        sendPkt(1, 2'd0, 32'h5);
        check("sat_hold", 32'(dropCount), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/udp_rx_packet_buffer.md
Name: udp_rx_packet_buffer

Overview:
Receive-side packet store in the sysClk domain. It consumes the 32-bit word stream delivered by the UDP serial port's receive FIFO (valid/ready/last, plus a 2-bit byte index) and assembles complete packets into a two-slot ping-pong RAM. It presents one finished packet at a time to the processor, together with its byte length. Packets that are oversize, or that arrive while both slots are occupied, are discarded whole and counted.

Parameters:
ADDR_WIDTH, 11, byte-address width of one packet slot; a slot holds 2^(ADDR_WIDTH-2) words.
DROP_WIDTH, 16, width of the saturating drop counter.

Ports:
sysClk  input  1  system clock; all logic on rising edge.
sysReset  input  1  asynchronous, active-high reset.
sysRxValid  input  1  stream word valid.
sysRxReady  output  1  stream ready.
sysRxLast  input  1  word is the final word of its packet.
sysByteIndex  input  2  on the last word, index of the final valid byte (0..3); ignored otherwise.
sysRxData  input  32  stream word.
cpuReadAddr  input  ADDR_WIDTH-2  word address within the presented packet.
cpuReadData  output  32  RAM read data, registered.
pktAvail  output  1  a complete packet is being presented.
pktLength  output  ADDR_WIDTH+1  byte length of the presented packet.
pktRelease  input  1  single-cycle pulse: processor is finished with the presented packet.
dropCount  output  DROP_WIDTH  packets discarded since reset; saturating.

Behaviour:
- Reset values: sysRxReady=0, cpuReadData=0, pktAvail=0, pktLength=0, dropCount=0. Internal state after reset: both slot-full flags clear, wrSlot=0, rdSlot=0, write FSM in IDLE.
- Reset is asserted asynchronously and released on the next clock edge. Reset mid-packet abandons all state. Upstream guarantees the stream restarts on a packet boundary.
- sysRxReady=1 in every cycle after reset; the block never back-pressures. A beat is accepted when sysRxValid=1.
- RAM: 2*2^(ADDR_WIDTH-2) words, addressed as {slot, wordAddr}. One write port (stream) and one read port (CPU).
- Write FSM states:
  - IDLE, on an accepted beat:
    - If full[wrSlot]: drop the packet and increment dropCount. If sysRxLast, stay in IDLE; otherwise go to DISCARD.
    - Otherwise: write the word at wordAddr 0 and set wordCount=1. If sysRxLast, complete the packet; otherwise go to FILL.
  - FILL, on an accepted beat:
    - If wordCount == 2^(ADDR_WIDTH-2) (slot already full of words): the packet is oversize. Do not write; increment dropCount; go to DISCARD, or to IDLE if sysRxLast.
    - Otherwise: write at wordAddr=wordCount and increment wordCount. If sysRxLast, complete the packet and go to IDLE.
  - DISCARD: accept and ignore beats; go to IDLE on sysRxLast.
- Packet completion: length = 4*(wordCount_before_last_beat) + sysByteIndex + 1. Store it in len[wrSlot], set full[wrSlot], toggle wrSlot. Length range is 1..2^ADDR_WIDTH bytes.
- Word data is stored unmodified. Byte lanes beyond the length in the final word are don't-care.
- Read side:
  - pktAvail = full[rdSlot], registered. It asserts the cycle after the completing beat, when rdSlot holds that packet.
  - pktLength = len[rdSlot], registered, and valid whenever pktAvail=1.
  - cpuReadData = RAM[{rdSlot, cpuReadAddr}], one-cycle latency. The address is not range-checked.
  - pktRelease with pktAvail=1: clear full[rdSlot] and toggle rdSlot. pktAvail and pktLength then reflect the other slot on the following cycle.
  - pktRelease with pktAvail=0 is ignored.
- Simultaneous events:
  - Completion into one slot and release of the other slot in the same cycle: both take effect.
  - Release and a first beat of a new packet in the same cycle: the writer sees full[] as it was before the release, so the packet is dropped. This is intended, conservative behaviour.
- dropCount saturates at all-ones; it never wraps.

Test Plan:
1. 9-byte packet: 3 words (0x11111111, 0x22222222, 0x33333333), last sysByteIndex=0 -> pktAvail=1 one cycle after the last beat; pktLength=9; cpuReadAddr 0..2 return the three words with 1-cycle latency.
2. Single-word packets with sysByteIndex=3, then sysByteIndex=0 -> pktLength=4; after pktRelease, pktLength=1.
3. Three 8-byte packets with no release -> first two stored; third dropped, dropCount=1. Release -> second packet presented. A fourth packet is then accepted into the freed slot.
4. ADDR_WIDTH=11: 513-word packet followed by a 4-byte packet -> first dropped (dropCount=1, no pktAvail); second presented with pktLength=4. Also: a 512-word packet with sysByteIndex=3 -> pktLength=2048.
5. pktRelease pulsed while pktAvail=0 -> no state change. Release of slot 0 coincident with completion into slot 1 -> slot 1 is presented on the next cycle, with correct pktLength.
6. Assert sysReset mid-packet (word 5 of 10) -> all outputs go to reset values immediately. After release, a fresh 12-byte packet is presented from slot 0 with pktLength=12 and dropCount=0. Separately, force the drop counter to all-ones and drop one more packet -> dropCount stays at all-ones.
